jtpang_objdma: RTL and testbench
================================

# jtpang_objdma

Object DMA engine between the main CPU bus and the object line renderer. On each request from the main CPU it takes the Z80 bus and copies object attribute RAM into the renderer's private object buffer, byte by byte. This lets the renderer scan a stable table while the CPU rewrites its own copy. It sits inside the video block and drives the `busrq`/`busak_n` pair that the game top wires back to the main CPU.

## Interface
Parameters:
- `AW`, 9: byte address width. One transfer is 2^AW bytes, i.e. 128 objects × 4 bytes.

Ports:
- `clk` in 1: system clock; one clock for the whole block.
- `rst` in 1: reset, synchronous, active-high.
- `cen` in 1: step enable (pixel cen, 6 MHz). All FSM and counter steps occur only when `cen`=1.
- `dma_go` in 1: DMA request from the main CPU decoder. Rising-edge triggered.
- `busak_n` in 1: Z80 bus acknowledge, active-low.
- `busrq` out 1: bus request to the CPU, active-high. The game top inverts it for the CPU.
- `ram_addr` out AW: source (CPU-side object RAM) byte address.
- `ram_dout` in 8: source read data, valid one `cen` step after `ram_addr`.
- `buf_addr` out AW: destination object buffer address.
- `buf_din` out 8: destination write data.
- `buf_we` out 1: destination write strobe, one `clk` wide, coincident with a `cen` step.
- `busy` out 1: high from request acceptance until the bus is released.

## Operation
- Edge detect: `dma_go` is sampled every `clk`. A 0→1 transition sets `pend`.
- A new edge while `busy`=1 also sets `pend`. The transfer then re-runs in full after the current one completes.
- FSM states: IDLE, REQ, COPY, FLUSH, REL.
- IDLE: with `pend`=1 at a `cen` step, clear `pend`, set `busrq`=1 and `busy`=1, clear `cnt`, go to REQ.
- REQ: wait for `busak_n`=0 at a `cen` step, then go to COPY.
- COPY: each `cen` step performs two actions at once:
  - drive `ram_addr`=`cnt`;
  - if `cnt`>0, write `ram_dout` to `buf_addr`=`cnt`−1.
  - Then `cnt` increments. When `cnt` wraps from 2^AW−1, go to FLUSH.
- FLUSH: one `cen` step that writes the final byte to `buf_addr`=2^AW−1. Then drop `busrq`, go to REL.
- REL: wait for `busak_n`=1 at a `cen` step, then drop `busy`, go to IDLE. No new request is raised while the CPU still acknowledges.
- `busak_n` returns to 1 during COPY (protocol violation): freeze `cnt`, suppress `buf_we`, keep `busrq`=1. Resume when `busak_n`=0. No byte is skipped or duplicated.
- `cnt` is AW+1 bits wide so the wrap is detected explicitly. `ram_addr` and `buf_addr` are its low AW bits.

## Timing
- Reset values: `busrq`=0, `busy`=0, `buf_we`=0, `ram_addr`=0, `buf_addr`=0, `buf_din`=0, `pend`=0, state IDLE.
- Reset mid-transfer: `busrq` is 0 on the `clk` after `rst` is sampled high. The partially written buffer is left as is.
- Request latency: `busrq` rises at the first `cen` step after the `dma_go` edge.
- Copy length, acknowledge to release: exactly 2^AW+1 `cen` steps (513 for AW=9).
- Write count: exactly 2^AW `buf_we` pulses per transfer, at addresses 0…2^AW−1 in ascending order.
- `buf_we` is asserted only on `clk` cycles where `cen`=1.
- Simultaneous events:
  - `dma_go` edge on the same `clk` that REL exits: `pend` is set, and the next transfer starts at the following `cen` step.
  - `rst` overrides everything.

## Structure
- Shared package `jtpang_pkg`:
  - state encoding constants: IDLE=0, REQ=1, COPY=2, FLUSH=3, REL=4;
  - object table size constant `OBJ_BYTES`=512.
- No sub-module. The edge detector and the counter are inline.

## Test plan
- Basic transfer, AW=9: source RAM model holds byte = address[7:0]. Pulse `dma_go`, with the CPU model returning `busak_n`=0 two steps after `busrq`. Required:
  - 512 `buf_we` pulses;
  - buffer[n] == n[7:0];
  - `busrq` falls 513 `cen` steps after acknowledge.
- Late acknowledge: hold `busak_n`=1 for 50 steps after `busrq`. Required: no `buf_we` and `busy`=1 throughout, then a normal transfer.
- Re-trigger: a second `dma_go` edge at byte 100 of the copy. Required: first transfer completes, `busrq` drops, waits for `busak_n`=1, then exactly one more full 512-byte transfer.
- Acknowledge glitch: `busak_n`=1 for 3 steps at `cnt`=200. Required:
  - no writes during the glitch;
  - the next write lands at address 199 (the byte whose address was issued just before the glitch);
  - total still 512 writes with no gaps or duplicates.
- Reset mid-copy: assert `rst` at byte 300. Required:
  - `busrq`=0 and `busy`=0 on the next `clk`;
  - a later `dma_go` performs a full transfer starting at address 0.
- Cen gating: hold `cen` low for 10 `clk` during COPY. Required: outputs and `cnt` hold and `buf_we`=0 for those cycles.

Source files
------------

// File: rtl/jtpang_pkg.sv
// Shared definitions for the object DMA: state encoding and object table size.
package jtpang_pkg;

  localparam int OBJ_BYTES = 512;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    COPY  = 3'd2,
    FLUSH = 3'd3,
    REL   = 3'd4
  } state_t;

endpackage

// File: rtl/jtpang_objdma.sv
// Object DMA: takes the Z80 bus on a dma_go edge and copies object attribute
// RAM into the renderer's private object buffer, one byte per cen step.
//
// state | meaning
// IDLE  | waiting for a pending request
// REQ   | busrq raised, waiting for busak_n low
// COPY  | issuing source addresses, writing the byte read one step earlier
// FLUSH | writing the last byte still in flight from the source RAM
// REL   | busrq dropped, waiting for the CPU to release busak_n
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_dout,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_din,
  output logic          buf_we,
  output logic          busy
);

  state_t      st, st_nx;
  logic [AW:0] cnt, cnt_nx;
  logic        go_q, pend;
  logic        go_edge, ack, stall, wr_ok;
  logic [AW-1:0] cnt_m1;

  assign go_edge = dma_go & ~go_q;
  assign ack     = ~busak_n;
  assign cnt_m1  = cnt[AW-1:0] - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      cnt  <= '0;
      go_q <= 1'b0;
      pend <= 1'b0;
    end else begin
      go_q <= dma_go;
      st   <= st_nx;
      cnt  <= cnt_nx;
      // a fresh edge wins over the clear so a request landing on acceptance is not lost
      if (go_edge)
        pend <= 1'b1;
      else if (cen && st == IDLE)
        pend <= 1'b0;
    end
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    if (cen) begin
      case (st)
        IDLE: if (pend) begin
          st_nx  = REQ;
          cnt_nx = '0;
        end
        REQ: if (ack) st_nx = COPY;
        COPY: if (ack) begin
          cnt_nx = cnt + 1'b1;
          if (cnt[AW-1:0] == '1) st_nx = FLUSH;
        end
        FLUSH: st_nx = REL;
        REL: if (!ack) st_nx = IDLE;
        default: st_nx = IDLE;
      endcase
    end
  end

  // While the CPU wrongly drops its acknowledge, keep re-reading the last issued
  // byte so the source RAM output still holds it when the copy resumes.
  assign stall    = (st == COPY) && !ack && (cnt != '0);
  assign ram_addr = stall ? cnt_m1 : cnt[AW-1:0];

  assign wr_ok    = ((st == COPY) || (st == FLUSH)) && (cnt != '0);
  assign buf_addr = wr_ok ? cnt_m1 : '0;
  assign buf_din  = wr_ok ? ram_dout : 8'd0;
  assign buf_we   = wr_ok && cen && !rst && ((st == FLUSH) || ack);

  assign busrq = (st == REQ) || (st == COPY) || (st == FLUSH);
  assign busy  = (st != IDLE);

endmodule

// File: tb/tb_jtpang_objdma.sv
// Self-checking bench for jtpang_objdma: CPU/RAM models plus a transfer-level scoreboard.
module tb_jtpang_objdma;
  localparam int AW = 9;
  localparam int N  = jtpang_pkg::OBJ_BYTES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic          dma_go = 1'b0;
  logic          busak_n = 1'b1;
  logic          busrq, buf_we, busy;
  logic [AW-1:0] ram_addr, buf_addr;
  logic [7:0]    ram_dout = 8'd0;
  logic [7:0]    buf_din;

  jtpang_objdma #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go), .busak_n(busak_n),
    .busrq(busrq), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] src [N];
  logic [7:0] tb_buf [N];

  // source RAM: data appears one cen step after the address
  always @(posedge clk) if (cen) ram_dout <= src[ram_addr];

  int n_checks = 0, n_fail = 0;

  // CPU model knobs
  int ack_delay = 2, rel_delay = 1;
  int rq_cnt = 0, rel_cnt = 0, glitch_left = 0, hold_left = 0;
  bit glitch_arm = 0, hold_req = 0, holding = 0, cen_ph = 0;
  logic [AW-1:0] snap_ra, snap_ba;

  // scoreboard state
  int wr_cnt, order_err, data_err, we_nocen, we_nak, preack_steps, preack_err;
  int step_cnt, early_req, rel_wait, glitch_steps, hold_cycles, hold_err;
  int first_after, last_wr;
  bit in_copy, prev_busrq, wr_seen, glitch_pend;
  logic [AW-1:0] wr_next;
  int xfer_wr[$];
  int xfer_len[$];

  task automatic clear_stats();
    wr_cnt = 0; order_err = 0; data_err = 0; we_nocen = 0; we_nak = 0;
    preack_steps = 0; preack_err = 0; step_cnt = 0; early_req = 0; rel_wait = 0;
    glitch_steps = 0; hold_cycles = 0; hold_err = 0; first_after = -1; last_wr = -1;
    in_copy = 0; wr_seen = 0; glitch_pend = 0; wr_next = '0;
    xfer_wr.delete(); xfer_len.delete();
  endtask

  // CPU bus model, cen generator and output monitor
  initial begin
    clear_stats();
    prev_busrq = 0;
    forever begin
      @(negedge clk);
      holding = 0;
      if (cen && hold_req) begin
        hold_req = 0; hold_left = 10; snap_ra = ram_addr; snap_ba = buf_addr;
      end
      if (cen) begin
        if (glitch_arm && busrq && !busak_n && ram_addr == 9'd200) begin
          glitch_left = 3; glitch_arm = 0;
        end
        if (busrq) begin
          rel_cnt = 0; rq_cnt++;
          if (glitch_left > 0) begin busak_n = 1'b1; glitch_left--; end
          else busak_n = (rq_cnt < ack_delay);
        end else begin
          rq_cnt = 0;
          if (!busak_n) begin
            rel_cnt++;
            if (rel_cnt >= rel_delay) busak_n = 1'b1;
          end
        end
      end
      if (hold_left > 0) begin cen = 1'b0; hold_left--; holding = 1; end
      else begin cen_ph = ~cen_ph; cen = cen_ph; end
      #1;
      if (buf_we) begin
        if (!cen) we_nocen++;
        if (busak_n) we_nak++;
        if (buf_addr !== wr_next) order_err++;
        if (buf_din !== src[buf_addr]) data_err++;
        tb_buf[buf_addr] = buf_din;
        wr_next = buf_addr + 1'b1;
        wr_cnt++; last_wr = int'(buf_addr); wr_seen = 1;
        if (glitch_pend) begin first_after = int'(buf_addr); glitch_pend = 0; end
      end
      if (cen && busrq) begin
        if (!in_copy && !busak_n) begin in_copy = 1; step_cnt = 0; end
        else if (in_copy) step_cnt++;
        else begin preack_steps++; if (!busy || buf_we) preack_err++; end
        if (in_copy && busak_n) begin glitch_pend = 1; glitch_steps++; end
      end
      if (holding) begin
        hold_cycles++;
        if (ram_addr !== snap_ra || buf_addr !== snap_ba || busrq !== 1'b1 ||
            busy !== 1'b1 || buf_we !== 1'b0) hold_err++;
      end
      if (busy && !busrq && cen && !busak_n) rel_wait++;
      if (!prev_busrq && busrq && !busak_n) early_req++;
      if (prev_busrq && !busrq) begin
        xfer_wr.push_back(wr_cnt); xfer_len.push_back(step_cnt);
        wr_cnt = 0; wr_next = '0; in_copy = 0;
      end
      prev_busrq = busrq;
    end
  end

  task automatic align_step();
    do begin @(posedge clk); #2; end while (!cen);
  endtask

  task automatic pulse_go();
    align_step();
    dma_go = 1'b1;
    repeat (2) @(posedge clk);
    #2 dma_go = 1'b0;
  endtask

  task automatic wait_xfers(input int n, output bit to);
    int k = 0;
    to = 0;
    while (!(xfer_wr.size() >= n && !busy)) begin
      @(posedge clk); #2; k++;
      if (k > 3000 * n) begin to = 1; break; end
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic wait_wr(input int addr, output bit to);
    int k = 0;
    to = 0;
    while (!(wr_seen && last_wr == addr)) begin
      @(posedge clk); #2; k++;
      if (k > 4000) begin to = 1; break; end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) src[i] = 8'($urandom);
    for (int i = 0; i < N; i++) tb_buf[i] = 8'hxx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (busrq !== 1'b0) begin n_fail++; $display("FAIL reset_busrq: got %b want 0", busrq); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (buf_we !== 1'b0) begin n_fail++; $display("FAIL reset_buf_we: got %b want 0", buf_we); end
    n_checks++; if (ram_addr !== 9'd0) begin n_fail++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
    n_checks++; if (buf_addr !== 9'd0) begin n_fail++; $display("FAIL reset_buf_addr: got %0d want 0", buf_addr); end
    n_checks++; if (buf_din !== 8'd0) begin n_fail++; $display("FAIL reset_buf_din: got %0d want 0", buf_din); end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    n_checks++; if (busrq !== 1'b0) begin n_fail++; $display("FAIL idle_no_request: got %b want 0", busrq); end
  endtask

  task automatic test_basic();
    bit to;
    int bad = 0;
    for (int i = 0; i < N; i++) src[i] = 8'(i);
    ack_delay = 2; rel_delay = 1;
    clear_stats();
    align_step();
    dma_go = 1'b1;
    @(posedge clk); #2;
    n_checks++; if (busrq !== 1'b0) begin n_fail++; $display("FAIL latency_early: busrq got %b want 0", busrq); end
    @(posedge clk); #2;
    n_checks++; if (busrq !== 1'b1) begin n_fail++; $display("FAIL latency_first_step: busrq got %b want 1", busrq); end
    dma_go = 1'b0;
    wait_xfers(1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: transfers got %0d want 1", xfer_wr.size()); end
    n_checks++; if (xfer_wr[0] !== N) begin n_fail++; $display("FAIL basic_writes: got %0d want %0d", xfer_wr[0], N); end
    n_checks++; if (xfer_len[0] !== N + 1) begin n_fail++; $display("FAIL basic_length: got %0d want %0d", xfer_len[0], N + 1); end
    n_checks++; if (order_err !== 0) begin n_fail++; $display("FAIL basic_order: got %0d errors want 0", order_err); end
    for (int i = 0; i < N; i++) if (tb_buf[i] !== 8'(i)) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL basic_buffer: got %0d bad bytes want 0", bad); end
    n_checks++; if (preack_steps !== 1) begin n_fail++; $display("FAIL basic_ack_wait: got %0d steps want 1", preack_steps); end
    n_checks++; if (we_nocen !== 0) begin n_fail++; $display("FAIL we_without_cen: got %0d want 0", we_nocen); end
  endtask

  task automatic test_late_ack();
    bit to;
    fill_random();
    ack_delay = 50; rel_delay = 1;
    clear_stats();
    pulse_go();
    wait_xfers(1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL late_timeout: transfers got %0d want 1", xfer_wr.size()); end
    n_checks++; if (preack_steps !== 49) begin n_fail++; $display("FAIL late_wait_steps: got %0d want 49", preack_steps); end
    n_checks++; if (preack_err !== 0) begin n_fail++; $display("FAIL late_busy_or_write: got %0d want 0", preack_err); end
    n_checks++; if (xfer_wr[0] !== N) begin n_fail++; $display("FAIL late_writes: got %0d want %0d", xfer_wr[0], N); end
    n_checks++; if (data_err !== 0) begin n_fail++; $display("FAIL late_data: got %0d errors want 0", data_err); end
  endtask

  task automatic test_retrigger();
    bit to;
    fill_random();
    ack_delay = 2; rel_delay = 4;
    clear_stats();
    pulse_go();
    wait_wr(100, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL retrig_reach_100: last write got %0d want 100", last_wr); end
    pulse_go();
    wait_xfers(2, to);
    repeat (1500) @(posedge clk);
    #2;
    n_checks++; if (xfer_wr.size() !== 2) begin n_fail++; $display("FAIL retrig_count: got %0d want 2", xfer_wr.size()); end
    n_checks++; if (xfer_wr[0] !== N) begin n_fail++; $display("FAIL retrig_first_writes: got %0d want %0d", xfer_wr[0], N); end
    n_checks++; if (xfer_wr[1] !== N) begin n_fail++; $display("FAIL retrig_second_writes: got %0d want %0d", xfer_wr[1], N); end
    n_checks++; if (order_err + data_err !== 0) begin n_fail++; $display("FAIL retrig_content: got %0d errors want 0", order_err + data_err); end
    n_checks++; if (early_req !== 0) begin n_fail++; $display("FAIL retrig_req_during_ack: got %0d want 0", early_req); end
    n_checks++; if (rel_wait !== 2 * (rel_delay - 1)) begin n_fail++; $display("FAIL retrig_release_wait: got %0d want %0d", rel_wait, 2 * (rel_delay - 1)); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL retrig_final_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    bit to;
    fill_random();
    ack_delay = int'($urandom_range(1, 4)); rel_delay = 1;
    clear_stats();
    glitch_arm = 1;
    pulse_go();
    wait_xfers(1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL glitch_timeout: transfers got %0d want 1", xfer_wr.size()); end
    n_checks++; if (glitch_steps !== 3) begin n_fail++; $display("FAIL glitch_steps: got %0d want 3", glitch_steps); end
    n_checks++; if (we_nak !== 0) begin n_fail++; $display("FAIL glitch_write_without_ack: got %0d want 0", we_nak); end
    n_checks++; if (first_after !== 199) begin n_fail++; $display("FAIL glitch_resume_addr: got %0d want 199", first_after); end
    n_checks++; if (xfer_wr[0] !== N) begin n_fail++; $display("FAIL glitch_writes: got %0d want %0d", xfer_wr[0], N); end
    n_checks++; if (order_err + data_err !== 0) begin n_fail++; $display("FAIL glitch_content: got %0d errors want 0", order_err + data_err); end
  endtask

  task automatic test_reset_mid();
    bit to;
    fill_random();
    ack_delay = 2; rel_delay = 1;
    clear_stats();
    pulse_go();
    wait_wr(300, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_reach_300: last write got %0d want 300", last_wr); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busrq !== 1'b0) begin n_fail++; $display("FAIL rstmid_busrq: got %b want 0", busrq); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (100) @(posedge clk);
    fill_random();
    clear_stats();
    pulse_go();
    wait_xfers(1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_timeout: transfers got %0d want 1", xfer_wr.size()); end
    n_checks++; if (xfer_wr[0] !== N) begin n_fail++; $display("FAIL rstmid_writes: got %0d want %0d", xfer_wr[0], N); end
    n_checks++; if (order_err + data_err !== 0) begin n_fail++; $display("FAIL rstmid_content: got %0d errors want 0", order_err + data_err); end
  endtask

  task automatic test_cen_gate();
    bit to;
    fill_random();
    ack_delay = 3; rel_delay = 2;
    clear_stats();
    pulse_go();
    wait_wr(50, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL cengate_reach_50: last write got %0d want 50", last_wr); end
    hold_req = 1;
    wait_xfers(1, to);
    n_checks++; if (hold_cycles !== 10) begin n_fail++; $display("FAIL cengate_cycles: got %0d want 10", hold_cycles); end
    n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL cengate_hold: got %0d changed cycles want 0", hold_err); end
    n_checks++; if (we_nocen !== 0) begin n_fail++; $display("FAIL cengate_we: got %0d want 0", we_nocen); end
    n_checks++; if (xfer_wr[0] !== N) begin n_fail++; $display("FAIL cengate_writes: got %0d want %0d", xfer_wr[0], N); end
    n_checks++; if (order_err + data_err !== 0) begin n_fail++; $display("FAIL cengate_content: got %0d errors want 0", order_err + data_err); end
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int r = 0; r < 2; r++) begin
      fill_random();
      ack_delay = int'($urandom_range(1, 6)); rel_delay = int'($urandom_range(1, 5));
      clear_stats();
      pulse_go();
      wait_xfers(1, to);
      n_checks++; if (to || xfer_wr[0] !== N) begin n_fail++; $display("FAIL b2b_writes run %0d: got %0d want %0d", r, xfer_wr[0], N); end
      n_checks++; if (order_err + data_err !== 0) begin n_fail++; $display("FAIL b2b_content run %0d: got %0d errors want 0", r, order_err + data_err); end
      n_checks++; if (preack_steps !== ack_delay - 1) begin n_fail++; $display("FAIL b2b_ack_wait run %0d: got %0d want %0d", r, preack_steps, ack_delay - 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_late_ack();
    test_retrigger();
    test_glitch();
    test_reset_mid();
    test_cen_gate();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
